// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong match sequencer and the ball/paddle datapath and renderers.
// The master side is the sequencer. The slave side is the datapath/renderer (or a bench).
interface pong_game_ctrl_if;
    logic       start;
    logic       frame_tick;
    logic       goal_p1;
    logic       goal_p2;
    logic       paddle_hit;
    logic [3:0] difficulty;

    logic [2:0] state;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] speed;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;

    modport master (
        input  start, frame_tick, goal_p1, goal_p2, paddle_hit, difficulty,
        output state, ball_run, ball_reset, serve_dir, speed, score1, score2,
        output game_over, winner
    );

    modport slave (
        output start, frame_tick, goal_p1, goal_p2, paddle_hit, difficulty,
        input  state, ball_run, ball_reset, serve_dir, speed, score1, score2,
        input  game_over, winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: game state, scores, serve/point timing and ball speed.
// Optional feature macro RALLY_SPEEDUP_EN: speed rises with the paddle-hit count of the current rally.
//
// state | meaning
// IDLE  | waiting for start after reset
// SERVE | ball held at centre for SERVE_FRAMES frame ticks
// PLAY  | ball moving, goals are scored
// POINT | freeze for POINT_FRAMES frame ticks after a goal
// OVER  | a player reached WIN_SCORE, scores frozen until start
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 72,
    parameter int POINT_FRAMES = 36
) (
    input logic              clk32mhz,
    input logic              reset,
    pong_game_ctrl_if.master bus
);
    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CW         = $clog2(MAX_FRAMES + 1);

    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0] POINT_LOAD = CW'(POINT_FRAMES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] frame_cnt;
    logic          start_q;
    logic          reset_pend;
    logic [3:0]    score1_q;
    logic [3:0]    score2_q;
    logic [3:0]    speed_q;
    logic          ball_run_q;
    logic          ball_reset_q;
    logic          serve_dir_q;
    logic          game_over_q;
    logic          winner_q;

    logic          start_rise;
    logic          count_done;
    logic          new_game;
    logic          serve_entry;
    logic          goal1_only;
    logic          goal2_only;
    logic          goal_both;
    logic [3:0]    score1_inc;
    logic [3:0]    score2_inc;

    assign start_rise  = bus.start & ~start_q;
    assign count_done  = bus.frame_tick && (frame_cnt == '0);
    assign new_game    = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && start_rise;
    assign serve_entry = new_game || ((state_q == ST_POINT) && count_done);
    assign goal1_only  = bus.goal_p1 & ~bus.goal_p2;
    assign goal2_only  = bus.goal_p2 & ~bus.goal_p1;
    assign goal_both   = bus.goal_p1 & bus.goal_p2;
    // Scores stay below WIN in PLAY, so the increment cannot wrap.
    assign score1_inc  = score1_q + 4'd1;
    assign score2_inc  = score2_q + 4'd1;

    always_ff @(posedge clk32mhz) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            frame_cnt    <= '0;
            start_q      <= 1'b1;
            reset_pend   <= 1'b0;
            score1_q     <= 4'd0;
            score2_q     <= 4'd0;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b0;
            serve_dir_q  <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            start_q      <= bus.start;
            // A new game recentres the ball one cycle after entering SERVE.
            ball_reset_q <= reset_pend;
            reset_pend   <= 1'b0;

            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (new_game) begin
                        state_q     <= ST_SERVE;
                        frame_cnt   <= SERVE_LOAD;
                        score1_q    <= 4'd0;
                        score2_q    <= 4'd0;
                        serve_dir_q <= 1'b0;
                        game_over_q <= 1'b0;
                        winner_q    <= 1'b0;
                        reset_pend  <= 1'b1;
                    end
                end

                ST_SERVE: begin
                    if (count_done) begin
                        state_q    <= ST_PLAY;
                        ball_run_q <= 1'b1;
                    end else if (bus.frame_tick) begin
                        frame_cnt <= frame_cnt - CW'(1);
                    end
                end

                ST_PLAY: begin
                    if (goal1_only) begin
                        score1_q    <= score1_inc;
                        serve_dir_q <= 1'b0;
                        ball_run_q  <= 1'b0;
                        if (score1_inc == WIN) begin
                            state_q     <= ST_OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= 1'b0;
                        end else begin
                            state_q   <= ST_POINT;
                            frame_cnt <= POINT_LOAD;
                        end
                    end else if (goal2_only) begin
                        score2_q    <= score2_inc;
                        serve_dir_q <= 1'b1;
                        ball_run_q  <= 1'b0;
                        if (score2_inc == WIN) begin
                            state_q     <= ST_OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= 1'b1;
                        end else begin
                            state_q   <= ST_POINT;
                            frame_cnt <= POINT_LOAD;
                        end
                    end else if (goal_both) begin
                        state_q    <= ST_POINT;
                        frame_cnt  <= POINT_LOAD;
                        ball_run_q <= 1'b0;
                    end
                end

                ST_POINT: begin
                    if (count_done) begin
                        state_q      <= ST_SERVE;
                        frame_cnt    <= SERVE_LOAD;
                        ball_reset_q <= 1'b1;
                    end else if (bus.frame_tick) begin
                        frame_cnt <= frame_cnt - CW'(1);
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    ball_run_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef RALLY_SPEEDUP_EN
    logic [5:0] rally;
    logic [4:0] speed_sum;

    // Every four paddle hits in a rally add one speed step on top of difficulty.
    assign speed_sum = {1'b0, bus.difficulty} + {3'b000, rally[5:2]};

    always_ff @(posedge clk32mhz) begin
        if (!reset) begin
            rally   <= 6'd0;
            speed_q <= 4'd0;
        end else begin
            if (serve_entry) begin
                rally <= 6'd0;
            end else if ((state_q == ST_PLAY) && bus.paddle_hit && (rally != 6'd63)) begin
                rally <= rally + 6'd1;
            end
            speed_q <= (speed_sum > 5'd15) ? 4'd15 : speed_sum[3:0];
        end
    end
`else
    logic unused_rally_inputs;
    assign unused_rally_inputs = bus.paddle_hit | serve_entry;

    always_ff @(posedge clk32mhz) begin
        if (!reset) begin
            speed_q <= 4'd0;
        end else begin
            speed_q <= bus.difficulty;
        end
    end
`endif

    assign bus.state      = state_q;
    assign bus.ball_run   = ball_run_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.speed      = speed_q;
    assign bus.score1     = score1_q;
    assign bus.score2     = score2_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match scenarios followed by random play,
// all checked each cycle against a frame-counting model of the game rules.
module tb_pong_game_ctrl;
    localparam int WIN_SCORE    = 9;
    localparam int SERVE_FRAMES = 72;
    localparam int POINT_FRAMES = 36;

    logic clk32mhz = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_FRAMES(SERVE_FRAMES),
        .POINT_FRAMES(POINT_FRAMES)
    ) dut (
        .clk32mhz(clk32mhz),
        .reset   (reset),
        .bus     (bus.master)
    );

    always #5 clk32mhz = ~clk32mhz;

    // Model: states by their output code, frame ticks counted upward per wait.
    int m_state, m_s1, m_s2, m_ticks, m_speed, m_rally;
    bit m_dir, m_run, m_brst, m_pend, m_over, m_win, m_start_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic begin_serve();
        m_state = 1;
        m_ticks = 0;
        m_rally = 0;
    endtask

    task automatic model_update();
        bit rise;
        if (!reset) begin
            m_state = 0; m_s1 = 0; m_s2 = 0; m_ticks = 0; m_speed = 0; m_rally = 0;
            m_dir = 0; m_run = 0; m_brst = 0; m_pend = 0; m_over = 0; m_win = 0;
            m_start_prev = 1;
            return;
        end
        rise = bus.start && !m_start_prev;
        m_start_prev = bus.start;
        m_brst = m_pend;
        m_pend = 0;
`ifdef RALLY_SPEEDUP_EN
        m_speed = (int'(bus.difficulty) + m_rally / 4 > 15) ? 15 : int'(bus.difficulty) + m_rally / 4;
`else
        m_speed = int'(bus.difficulty);
`endif
        case (m_state)
            0, 4: if (rise) begin
                begin_serve();
                m_s1 = 0; m_s2 = 0; m_dir = 0; m_over = 0; m_win = 0; m_pend = 1;
            end
            1: if (bus.frame_tick) begin
                m_ticks++;
                if (m_ticks == SERVE_FRAMES) begin
                    m_state = 2;
                    m_run = 1;
                end
            end
            2: begin
                if (bus.paddle_hit && m_rally < 63) m_rally++;
                if (bus.goal_p1 || bus.goal_p2) begin
                    m_run = 0;
                    m_state = 3;
                    m_ticks = 0;
                    if (bus.goal_p1 && !bus.goal_p2) begin
                        m_s1++;
                        m_dir = 0;
                        if (m_s1 == WIN_SCORE) begin m_state = 4; m_over = 1; m_win = 0; end
                    end else if (bus.goal_p2 && !bus.goal_p1) begin
                        m_s2++;
                        m_dir = 1;
                        if (m_s2 == WIN_SCORE) begin m_state = 4; m_over = 1; m_win = 1; end
                    end
                end
            end
            3: if (bus.frame_tick) begin
                m_ticks++;
                if (m_ticks == POINT_FRAMES) begin
                    begin_serve();
                    m_brst = 1;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all();
        chk("state",      32'(bus.state),      32'(m_state));
        chk("ball_run",   32'(bus.ball_run),   32'(m_run));
        chk("ball_reset", 32'(bus.ball_reset), 32'(m_brst));
        chk("serve_dir",  32'(bus.serve_dir),  32'(m_dir));
        chk("speed",      32'(bus.speed),      32'(m_speed));
        chk("score1",     32'(bus.score1),     32'(m_s1));
        chk("score2",     32'(bus.score2),     32'(m_s2));
        chk("game_over",  32'(bus.game_over),  32'(m_over));
        chk("winner",     32'(bus.winner),     32'(m_win));
    endtask

    task automatic step();
        @(posedge clk32mhz);
        model_update();
        #1;
        check_all();
    endtask

    task automatic clear_pulses();
        bus.frame_tick = 0; bus.goal_p1 = 0; bus.goal_p2 = 0; bus.paddle_hit = 0;
    endtask

    task automatic run_until(input int target, input int budget);
        bus.frame_tick = 1;
        for (int i = 0; i < budget && int'(bus.state) != target; i++) step();
        bus.frame_tick = 0;
        chk("reach_state", 32'(bus.state), 32'(target));
    endtask

    initial begin
        int keep_s1, keep_s2;
        reset = 0;
        bus.start = 1;
        bus.difficulty = 4'd13;
        clear_pulses();
        repeat (3) step();
        chk("rst_state", 32'(bus.state), 32'd0);

        // Start held through reset gives no edge.
        reset = 1;
        repeat (5) step();
        chk("held_idle", 32'(bus.state), 32'd0);
        chk("held_no_brst", 32'(bus.ball_reset), 32'd0);

        bus.start = 0; step();
        bus.start = 1; step();
        chk("serve_entry", 32'(bus.state), 32'd1);
        chk("brst_delayed", 32'(bus.ball_reset), 32'd0);
        step();
        chk("brst_pulse", 32'(bus.ball_reset), 32'd1);

        // 71 ticks keep SERVE; stray goals in SERVE are ignored.
        for (int i = 0; i < SERVE_FRAMES - 1; i++) begin
            bus.frame_tick = 1; step();
            bus.frame_tick = 0;
            bus.goal_p1 = ($urandom_range(0, 3) == 0);
            bus.goal_p2 = ($urandom_range(0, 3) == 0);
            step();
            clear_pulses();
        end
        chk("serve_71", 32'(bus.state), 32'd1);
        bus.frame_tick = 1; step(); bus.frame_tick = 0;
        chk("play_72", 32'(bus.state), 32'd2);
        chk("run_72", 32'(bus.ball_run), 32'd1);

        // Rally speed-up: 12 hits from difficulty 13.
        for (int i = 0; i < 12; i++) begin
            bus.paddle_hit = 1; step();
        end
        bus.paddle_hit = 0; step();
`ifdef RALLY_SPEEDUP_EN
        chk("speed_sat", 32'(bus.speed), 32'd15);
`else
        chk("speed_flat", 32'(bus.speed), 32'd13);
`endif
        bus.goal_p2 = 1; step(); bus.goal_p2 = 0;
        chk("p2_score", 32'(bus.score2), 32'd1);
        chk("p2_dir", 32'(bus.serve_dir), 32'd1);
        chk("p2_point", 32'(bus.state), 32'd3);
        bus.frame_tick = 1;
        repeat (POINT_FRAMES - 1) step();
        chk("point_35", 32'(bus.state), 32'd3);
        step(); bus.frame_tick = 0;
        chk("point_exp_state", 32'(bus.state), 32'd1);
        chk("point_exp_brst", 32'(bus.ball_reset), 32'd1);
        step();
        chk("speed_new_serve", 32'(bus.speed), 32'd13);

        // Player 1 wins 9-1.
        for (int g = 0; g < WIN_SCORE; g++) begin
            run_until(2, 300);
            bus.goal_p1 = 1; step(); bus.goal_p1 = 0;
        end
        chk("win_state", 32'(bus.state), 32'd4);
        chk("win_over", 32'(bus.game_over), 32'd1);
        chk("win_who", 32'(bus.winner), 32'd0);
        chk("win_s1", 32'(bus.score1), 32'(WIN_SCORE));
        bus.goal_p1 = 1; bus.goal_p2 = 1; bus.frame_tick = 1; step();
        bus.goal_p1 = 0; step(); clear_pulses();
        chk("over_frozen", 32'(bus.score2), 32'd1);
        bus.start = 0; step();
        bus.start = 1; step();
        chk("restart_state", 32'(bus.state), 32'd1);
        chk("restart_s1", 32'(bus.score1), 32'd0);

        // Simultaneous goals replay the point.
        run_until(2, 300);
        keep_s1 = int'(bus.score1); keep_s2 = int'(bus.score2);
        bus.goal_p1 = 1; bus.goal_p2 = 1; step(); clear_pulses();
        chk("both_state", 32'(bus.state), 32'd3);
        chk("both_s1", 32'(bus.score1), 32'(keep_s1));
        chk("both_s2", 32'(bus.score2), 32'(keep_s2));

        // Goal with frame_tick in the same cycle: POINT still lasts a full 36 ticks.
        run_until(2, 300);
        bus.goal_p1 = 1; bus.frame_tick = 1; step(); bus.goal_p1 = 0;
        repeat (POINT_FRAMES - 1) step();
        chk("tick_goal_hold", 32'(bus.state), 32'd3);
        step(); bus.frame_tick = 0;
        chk("tick_goal_exp", 32'(bus.state), 32'd1);

        // Reset mid-game, and reset while a recentre pulse is pending.
        run_until(2, 300);
        reset = 0; step(); reset = 1;
        chk("midrst_state", 32'(bus.state), 32'd0);
        chk("midrst_run", 32'(bus.ball_run), 32'd0);
        step();
        bus.start = 0; step();
        bus.start = 1; step();
        reset = 0; step(); reset = 1;
        chk("pend_rst_brst", 32'(bus.ball_reset), 32'd0);
        step();
        chk("pend_rst_brst2", 32'(bus.ball_reset), 32'd0);

        // Random play against the model.
        for (int c = 0; c < 15000; c++) begin
            bus.frame_tick = ($urandom_range(0, 1) == 1);
            bus.goal_p1    = ($urandom_range(0, 29) == 0);
            bus.goal_p2    = ($urandom_range(0, 19) == 0);
            bus.paddle_hit = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) bus.start = ~bus.start;
            if ($urandom_range(0, 149) == 0) bus.difficulty = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 4999) != 0);
            step();
        end
        reset = 1;
        clear_pulses();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
